// File: rtl/la_csa_accum.sv
// Multi-operand accumulator: operands fold into carry-save (sum, carry) state, then resolve K bits
// per cycle. Define LA_CSA_ACCUM_CNT_EN to add the saturating operand counter on out_cnt.
module la_csa_accum #(
  parameter int unsigned N      = 16,
  parameter int unsigned W      = 32,
  parameter int unsigned K      = 8,
  parameter int unsigned SIGNED = 0
`ifdef LA_CSA_ACCUM_CNT_EN
  ,
  parameter int unsigned CW     = 8
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          busy
`ifdef LA_CSA_ACCUM_CNT_EN
  ,
  output logic [CW-1:0] out_cnt
`endif
);

  localparam int unsigned NumChunks = W / K;
  localparam int unsigned IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

  if (W < N) begin : g_bad_width
    $error("la_csa_accum: W must be >= N");
  end
  if ((W % K) != 0) begin : g_bad_chunk
    $error("la_csa_accum: W must be a multiple of K");
  end

  typedef enum logic [1:0] {StAccum, StResolve, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    s_q, s_d;
  logic [W-1:0]    c_q, c_d;
  logic [W-1:0]    res_q, res_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            cy_q, cy_d;

  logic [W-1:0]    x;
  logic [W-1:0]    maj;
  logic [K:0]      chunk_sum;
  logic            in_fire;
  logic            out_fire;

  // Operand extension to accumulator width.
  if (W == N) begin : g_ext_none
    assign x = in_data;
  end else if (SIGNED != 0) begin : g_ext_sign
    assign x = {{(W - N){in_data[N-1]}}, in_data};
  end else begin : g_ext_zero
    assign x = {{(W - N){1'b0}}, in_data};
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign maj       = (s_q & c_q) | (c_q & x) | (x & s_q);
  assign chunk_sum = {1'b0, s_q[idx_q*K +: K]} + {1'b0, c_q[idx_q*K +: K]} + {{K{1'b0}}, cy_q};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum:   if (in_fire && in_last) state_d = StResolve;
      StResolve: if (idx_q == LastIdx)   state_d = StDone;
      StDone:    if (out_fire)           state_d = StAccum;
      default:   state_d = StAccum;
    endcase
  end

  // Handshake and status outputs.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StAccum:   in_ready  = 1'b1;
      StResolve: busy      = 1'b1;
      StDone: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath: carry-save fold while accumulating, one chunk per cycle while resolving.
  always_comb begin
    s_d   = s_q;
    c_d   = c_q;
    res_d = res_q;
    idx_d = idx_q;
    cy_d  = cy_q;
    unique case (state_q)
      StAccum: begin
        idx_d = '0;
        cy_d  = 1'b0;
        if (in_fire) begin
          s_d = s_q ^ c_q ^ x;
          c_d = maj << 1;
        end
      end
      StResolve: begin
        res_d[idx_q*K +: K] = chunk_sum[K-1:0];
        cy_d                = chunk_sum[K];
        idx_d               = idx_q + 1'b1;
      end
      StDone: begin
        if (out_fire) begin
          s_d = '0;
          c_d = '0;
        end
      end
      default: begin
        s_d = '0;
        c_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q   <= '0;
      c_q   <= '0;
      res_q <= '0;
      idx_q <= '0;
      cy_q  <= 1'b0;
    end else begin
      s_q   <= s_d;
      c_q   <= c_d;
      res_q <= res_d;
      idx_q <= idx_d;
      cy_q  <= cy_d;
    end
  end

  assign out_data = res_q;

`ifdef LA_CSA_ACCUM_CNT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire) begin
      cnt_d = '0;
    end else if (in_fire && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`endif

endmodule
